// File: rtl/usb_ctl_xfer_ctrl.sv
// usb_ctl_xfer_ctrl: EP0 control-transfer engine, device side.
// Define USB_CTL_STALL_EN to STALL rejected requests (else NAK).
module usb_ctl_xfer_ctrl #(
  parameter int MAX_PACKET_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trn_setup,
  input  logic        trn_in,
  input  logic        trn_out,
  input  logic [3:0]  trn_endpoint,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  input  logic        rx_tlast,
  input  logic        rx_crc_ok,
  input  logic        host_ack,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  output logic        tx_tlast,
  output logic        tx_zlp,
  input  logic        tx_tready,
  output logic        tx_data1,
  output logic        hsk_valid,
  output logic [1:0]  hsk_type,
  output logic [3:0]  ctl_xfer_endpoint,
  output logic [7:0]  ctl_xfer_type,
  output logic [7:0]  ctl_xfer_request,
  output logic [15:0] ctl_xfer_value,
  output logic [15:0] ctl_xfer_index,
  output logic [15:0] ctl_xfer_length,
  output logic        ctl_xfer,
  input  logic        ctl_xfer_accept,
  input  logic        ctl_xfer_done,
  output logic [7:0]  ctl_xfer_data_out,
  output logic        ctl_xfer_data_out_valid,
  input  logic [7:0]  ctl_xfer_data_in,
  input  logic        ctl_xfer_data_in_valid,
  input  logic        ctl_xfer_data_in_last,
  output logic        ctl_xfer_data_in_ready
);
  localparam int CW = $clog2(MAX_PACKET_SIZE) + 1;
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] MPS = CW'(MAX_PACKET_SIZE);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [1:0] H_ACK = 2'b00;
  localparam logic [1:0] H_NAK = 2'b01;
`ifdef USB_CTL_STALL_EN
  localparam logic [1:0] H_REJ = 2'b10;
`else
  localparam logic [1:0] H_REJ = 2'b01;
`endif

  typedef enum logic [3:0] {
    IDLE, SETUP_RX, DECODE, IN_FILL, IN_SEND,
    IN_WAIT, OUT_RX, STATUS_IN, STATUS_OUT, STALL
  } state_t;

  state_t        r_state;
  logic [7:0]    r_buf [MAX_PACKET_SIZE];
  logic [CW-1:0] r_cnt, r_idx;
  logic [15:0]   r_rem, r_pcnt;
  logic [3:0]    r_scnt, r_ep;
  logic          r_last, r_txact, r_zlp, r_tog;
  logic          r_dwait, r_sent, r_ctl;
  logic          r_hsk_v, r_dout_v;
  logic [1:0]    r_hsk_t;
  logic [7:0]    r_dout, r_type, r_req;
  logic [15:0]   r_val, r_windex, r_len;

  logic          w_ep0, w_setup, w_in, w_out;
  logic          w_fill_rdy, w_fin, w_tx_last, w_wr;
  logic [15:0]   w_rx_n;

  assign w_ep0      = (trn_endpoint == 4'd0);
  assign w_setup    = trn_setup && w_ep0;
  assign w_in       = trn_in && w_ep0;
  assign w_out      = trn_out && w_ep0;
  assign w_fill_rdy = (r_state == IN_FILL) && (r_cnt < MPS)
                   && (r_rem != 16'd0) && !r_last;
  assign w_wr       = w_fill_rdy && ctl_xfer_data_in_valid;
  assign w_fin      = (r_rem == 16'd0) || (r_last && r_cnt != MPS);
  assign w_tx_last  = r_zlp || (r_idx == r_cnt - ONE);
  assign w_rx_n     = r_pcnt + {15'd0, rx_tvalid};

  assign tx_tvalid  = r_txact;
  assign tx_tlast   = r_txact && w_tx_last;
  assign tx_zlp     = r_txact && r_zlp;
  assign tx_tdata   = (r_txact && !r_zlp)
                    ? r_buf[r_idx[AW-1:0]] : 8'd0;
  assign tx_data1   = r_tog;
  assign hsk_valid  = r_hsk_v;
  assign hsk_type   = r_hsk_t;
  assign ctl_xfer   = r_ctl;
  assign ctl_xfer_endpoint       = r_ep;
  assign ctl_xfer_type           = r_type;
  assign ctl_xfer_request        = r_req;
  assign ctl_xfer_value          = r_val;
  assign ctl_xfer_index          = r_windex;
  assign ctl_xfer_length         = r_len;
  assign ctl_xfer_data_out       = r_dout;
  assign ctl_xfer_data_out_valid = r_dout_v;
  assign ctl_xfer_data_in_ready  = w_fill_rdy;

  // IN packet buffer; contents only reach tx_tdata while sending
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_cnt[AW-1:0]] <= ctl_xfer_data_in;
  end

  // control-transfer sequencer with registered handshake/data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;   r_cnt <= '0;     r_idx <= '0;
      r_rem <= 16'd0;    r_pcnt <= 16'd0; r_scnt <= 4'd0;
      r_ep <= 4'd0;      r_last <= 1'b0;  r_txact <= 1'b0;
      r_zlp <= 1'b0;     r_tog <= 1'b0;   r_dwait <= 1'b0;
      r_sent <= 1'b0;    r_ctl <= 1'b0;   r_hsk_v <= 1'b0;
      r_hsk_t <= 2'b00;  r_dout <= 8'd0;  r_dout_v <= 1'b0;
      r_type <= 8'd0;    r_req <= 8'd0;   r_val <= 16'd0;
      r_windex <= 16'd0; r_len <= 16'd0;
    end else begin
      r_hsk_v  <= 1'b0;
      r_dout_v <= 1'b0;
      if (w_setup) begin
        r_state <= SETUP_RX;
        r_ctl   <= 1'b0;
        r_txact <= 1'b0;
        r_scnt  <= 4'd0;
        r_pcnt  <= 16'd0;
        r_ep    <= trn_endpoint;
      end else begin
        case (r_state)
          SETUP_RX: begin
            if (rx_tvalid) begin
              case (r_scnt)
                4'd0: r_type          <= rx_tdata;
                4'd1: r_req           <= rx_tdata;
                4'd2: r_val[7:0]      <= rx_tdata;
                4'd3: r_val[15:8]     <= rx_tdata;
                4'd4: r_windex[7:0]   <= rx_tdata;
                4'd5: r_windex[15:8]  <= rx_tdata;
                4'd6: r_len[7:0]      <= rx_tdata;
                4'd7: r_len[15:8]     <= rx_tdata;
                default: ;
              endcase
              if (r_scnt != 4'd15) r_scnt <= r_scnt + 4'd1;
            end
            if (rx_tlast) begin
              if (rx_crc_ok &&
                  (r_scnt + {3'd0, rx_tvalid}) == 4'd8) begin
                r_hsk_v <= 1'b1;
                r_hsk_t <= H_ACK;
                r_tog   <= 1'b1;
                r_ctl   <= 1'b1;
                r_dwait <= 1'b0;
                r_state <= DECODE;
              end else begin
                r_state <= IDLE;
              end
            end
          end
          DECODE: begin
            r_dwait <= 1'b1;
            if (r_dwait) begin
              r_rem  <= r_len;
              r_cnt  <= '0;
              r_last <= 1'b0;
              r_sent <= 1'b0;
              if (!ctl_xfer_accept)     r_state <= STALL;
              else if (r_len == 16'd0)  r_state <= STATUS_IN;
              else if (r_type[7])       r_state <= IN_FILL;
              else                      r_state <= OUT_RX;
            end
          end
          IN_FILL: begin
            if (w_in) begin
              r_hsk_v <= 1'b1;
              r_hsk_t <= H_NAK;
            end
            if (w_wr) begin
              r_cnt <= r_cnt + ONE;
              r_rem <= r_rem - 16'd1;
              if (ctl_xfer_data_in_last) r_last <= 1'b1;
            end else if (!w_fill_rdy) begin
              r_txact <= 1'b0;
              r_state <= IN_SEND;
            end
          end
          IN_SEND: begin
            if (!r_txact) begin
              if (w_in) begin
                r_txact <= 1'b1;
                r_idx   <= '0;
                r_zlp   <= (r_cnt == '0);
              end
            end else if (tx_tready) begin
              if (w_tx_last) begin
                r_txact <= 1'b0;
                r_state <= IN_WAIT;
              end else begin
                r_idx <= r_idx + ONE;
              end
            end
          end
          IN_WAIT: begin
            if (host_ack) begin
              r_tog <= ~r_tog;
              if (w_fin) begin
                r_state <= STATUS_OUT;
              end else begin
                r_cnt   <= '0;
                r_state <= IN_FILL;
              end
            end else if (w_in) begin
              r_txact <= 1'b1;
              r_idx   <= '0;
              r_state <= IN_SEND;
            end else if (w_out) begin
              r_state <= STATUS_OUT;
            end
          end
          OUT_RX: begin
            if (rx_tvalid) begin
              r_dout   <= rx_tdata;
              r_dout_v <= 1'b1;
            end
            if (rx_tlast) begin
              r_pcnt <= 16'd0;
              if (rx_crc_ok) begin
                r_hsk_v <= 1'b1;
                r_hsk_t <= H_ACK;
                r_tog   <= ~r_tog;
                if (w_rx_n >= r_rem) begin
                  r_sent  <= 1'b0;
                  r_state <= STATUS_IN;
                end else begin
                  r_rem <= r_rem - w_rx_n;
                end
              end
            end else if (rx_tvalid) begin
              r_pcnt <= r_pcnt + 16'd1;
            end
          end
          STATUS_IN: begin
            if (r_txact) begin
              if (tx_tready) begin
                r_txact <= 1'b0;
                r_sent  <= 1'b1;
              end
            end else if (w_in) begin
              if (!r_type[7] && !ctl_xfer_done) begin
                r_hsk_v <= 1'b1;
                r_hsk_t <= H_NAK;
              end else begin
                r_txact <= 1'b1;
                r_zlp   <= 1'b1;
                r_tog   <= 1'b1;
                r_idx   <= '0;
              end
            end else if (host_ack && r_sent) begin
              r_ctl   <= 1'b0;
              r_state <= IDLE;
            end
          end
          STATUS_OUT: begin
            if (rx_tlast) begin
              r_pcnt <= 16'd0;
              if (rx_crc_ok && w_rx_n == 16'd0) begin
                r_hsk_v <= 1'b1;
                r_hsk_t <= H_ACK;
                r_ctl   <= 1'b0;
                r_state <= IDLE;
              end
            end else if (rx_tvalid) begin
              r_pcnt <= r_pcnt + 16'd1;
            end
          end
          STALL: begin
            if (w_in || w_out) begin
              r_hsk_v <= 1'b1;
              r_hsk_t <= H_REJ;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_ctl_xfer_ctrl.sv
// tb_usb_ctl_xfer_ctrl: randomized scoreboard bench for the EP0 engine.
// Expected packets come from a packet-splitting model of the request rules.
`timescale 1ns/1ps
module tb_usb_ctl_xfer_ctrl;
  localparam int MPS = 8;
`ifdef USB_CTL_STALL_EN
  localparam int REJ = 2;
`else
  localparam int REJ = 1;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic trn_setup, trn_in, trn_out, rx_tvalid, rx_tlast, rx_crc_ok;
  logic [3:0] trn_endpoint;
  logic [7:0] rx_tdata, tx_tdata, ctl_xfer_type, ctl_xfer_request;
  logic host_ack, tx_tvalid, tx_tlast, tx_zlp, tx_tready, tx_data1;
  logic hsk_valid, ctl_xfer, ctl_xfer_accept, ctl_xfer_done;
  logic [1:0] hsk_type;
  logic [3:0] ctl_xfer_endpoint;
  logic [15:0] ctl_xfer_value, ctl_xfer_index, ctl_xfer_length;
  logic [7:0] ctl_xfer_data_out, ctl_xfer_data_in;
  logic ctl_xfer_data_out_valid, ctl_xfer_data_in_valid;
  logic ctl_xfer_data_in_last, ctl_xfer_data_in_ready;

  usb_ctl_xfer_ctrl #(.MAX_PACKET_SIZE(MPS)) dut (
    .clk(clk), .rst(rst),
    .trn_setup(trn_setup), .trn_in(trn_in), .trn_out(trn_out),
    .trn_endpoint(trn_endpoint),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
    .rx_tlast(rx_tlast), .rx_crc_ok(rx_crc_ok),
    .host_ack(host_ack),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
    .tx_zlp(tx_zlp), .tx_tready(tx_tready), .tx_data1(tx_data1),
    .hsk_valid(hsk_valid), .hsk_type(hsk_type),
    .ctl_xfer_endpoint(ctl_xfer_endpoint),
    .ctl_xfer_type(ctl_xfer_type),
    .ctl_xfer_request(ctl_xfer_request),
    .ctl_xfer_value(ctl_xfer_value),
    .ctl_xfer_index(ctl_xfer_index),
    .ctl_xfer_length(ctl_xfer_length),
    .ctl_xfer(ctl_xfer),
    .ctl_xfer_accept(ctl_xfer_accept),
    .ctl_xfer_done(ctl_xfer_done),
    .ctl_xfer_data_out(ctl_xfer_data_out),
    .ctl_xfer_data_out_valid(ctl_xfer_data_out_valid),
    .ctl_xfer_data_in(ctl_xfer_data_in),
    .ctl_xfer_data_in_valid(ctl_xfer_data_in_valid),
    .ctl_xfer_data_in_last(ctl_xfer_data_in_last),
    .ctl_xfer_data_in_ready(ctl_xfer_data_in_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int exp_q[$];
  int hdat[256];
  int h_n = 0, h_idx = 0;

  function automatic int e_hsk(int t);
    return (1 << 16) | t;
  endfunction
  function automatic int e_tx(int b, int d1, int z, int l);
    return (2 << 16) | (d1 << 10) | (z << 9) | (l << 8) | (z ? 0 : b);
  endfunction
  function automatic int e_out(int b);
    return (3 << 16) | b;
  endfunction

  task automatic chk(string nm, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  task automatic mon_one(string nm, int act);
    int e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: unexpected event %0h, required none", nm, act);
    end else begin
      e = exp_q.pop_front();
      chk(nm, act, e);
    end
  endtask

  // monitor: every DUT output event is matched against the scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ctl_xfer_data_out_valid)
        mon_one("out_byte", (3 << 16) | {24'd0, ctl_xfer_data_out});
      if (hsk_valid)
        mon_one("hsk", (1 << 16) | {30'd0, hsk_type});
      if (tx_tvalid && tx_tready)
        mon_one("tx_beat", (2 << 16) | {21'd0, tx_data1, tx_zlp,
                tx_tlast, tx_zlp ? 8'd0 : tx_tdata});
    end
  end

  // PHY back-pressure
  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // request handler supplying h_n bytes of hdat with last on the final one
  initial begin
    bit take;
    ctl_xfer_data_in_valid = 1'b0;
    ctl_xfer_data_in_last = 1'b0;
    ctl_xfer_data_in = 8'd0;
    forever begin
      @(negedge clk);
      take = ctl_xfer_data_in_valid && ctl_xfer_data_in_ready;
      @(posedge clk); #1;
      if (take) h_idx++;
      ctl_xfer_data_in_valid = (h_idx < h_n);
      ctl_xfer_data_in_last = (h_idx == h_n - 1);
      ctl_xfer_data_in = (h_idx < 256) ? 8'(hdat[h_idx]) : 8'd0;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic pulse_in(int ep = 0);
    trn_endpoint = 4'(ep); trn_in = 1'b1; tick();
    trn_in = 1'b0; trn_endpoint = 4'd0;
  endtask
  task automatic pulse_out();
    trn_out = 1'b1; tick(); trn_out = 1'b0;
  endtask
  task automatic pulse_ack();
    host_ack = 1'b1; tick(); host_ack = 1'b0;
  endtask

  task automatic rx_pkt(int len, int crc, input int b[$]);
    for (int i = 0; i < len; i++) begin
      rx_tvalid = 1'b1; rx_tdata = 8'(b[i]);
      rx_tlast = (i == len - 1); rx_crc_ok = 1'(crc); tick();
    end
    if (len == 0) begin
      rx_tlast = 1'b1; rx_crc_ok = 1'(crc); tick();
    end
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_crc_ok = 1'b0;
  endtask

  task automatic setup(int typ, int req, int val, int len,
                       int crc = 1, int nb = 8);
    int b[$];
    b.push_back(typ); b.push_back(req);
    b.push_back(val & 255); b.push_back(val >> 8);
    b.push_back(0); b.push_back(0);
    b.push_back(len & 255); b.push_back(len >> 8);
    trn_setup = 1'b1; tick(); trn_setup = 1'b0;
    if (crc != 0 && nb == 8) exp_q.push_back(e_hsk(0));
    rx_pkt(nb, crc, b);
    tick(3);
  endtask

  task automatic wait_txlast();
    int k = 0;
    bit seen = 0;
    while (!seen && k < 300) begin
      @(negedge clk);
      seen = tx_tvalid && tx_tready && tx_tlast;
      k++;
    end
    @(posedge clk); #1;
    chk("tx_packet_end", int'(seen), 1);
  endtask

  task automatic push_pkt(int off, int len, int tog);
    if (len == 0) exp_q.push_back(e_tx(0, tog, 1, 1));
    else for (int i = 0; i < len; i++)
      exp_q.push_back(e_tx(hdat[off + i], tog, 0, int'(i == len - 1)));
  endtask

  task automatic status_out();
    int nob[$];
    chk("ctl_xfer_held", int'(ctl_xfer), 1);
    exp_q.push_back(e_hsk(0));
    rx_pkt(0, 1, nob);
    tick(2);
    chk("ctl_xfer_fall", int'(ctl_xfer), 0);
    chk("drain", exp_q.size(), 0);
  endtask

  // IN request: wLength L, handler offers N bytes
  task automatic in_xfer(int L, int N, int nak1, int retry, int early);
    int t, np, zlp, off, len, tog, reps;
    int nob[$];
    for (int i = 0; i < 256; i++) hdat[i] = $urandom_range(0, 255);
    h_n = N; h_idx = 0;
    setup(8'h80, 6, 16'h0100, L);
    chk("length", int'(ctl_xfer_length), L);
    chk("type", int'(ctl_xfer_type), 8'h80);
    if (nak1 != 0) begin exp_q.push_back(e_hsk(1)); pulse_in(); end
    t = (L < N) ? L : N;
    np = (t + MPS - 1) / MPS;
    zlp = int'((t % MPS) == 0 && t < L);
    off = 0; tog = 1;
    for (int p = 0; p < np + zlp; p++) begin
      len = (t - off < MPS) ? t - off : MPS;
      reps = (p == 0 && retry != 0) ? 2 : 1;
      for (int r = 0; r < reps; r++) begin
        push_pkt(off, len, tog);
        tick(MPS + 4);
        pulse_in();
        wait_txlast();
      end
      if (early != 0) begin pulse_out(); break; end
      pulse_ack();
      tog ^= 1; off += len;
    end
    tick(2);
    rx_pkt(0, 0, nob);
    tick(2);
    chk("bad_crc_status_keeps_xfer", int'(ctl_xfer), 1);
    status_out();
    h_n = 0;
  endtask

  // zero-length OUT-direction request that completes via STATUS_IN
  task automatic status_in(int nak);
    if (nak != 0) begin
      ctl_xfer_done = 1'b0;
      exp_q.push_back(e_hsk(1)); pulse_in(); tick(2);
    end
    ctl_xfer_done = 1'b1;
    exp_q.push_back(e_tx(0, 1, 1, 1));
    pulse_in(); wait_txlast();
    chk("ctl_xfer_until_ack", int'(ctl_xfer), 1);
    pulse_ack(); tick();
    chk("ctl_xfer_after_ack", int'(ctl_xfer), 0);
    chk("drain", exp_q.size(), 0);
    ctl_xfer_done = 1'b0;
  endtask

  task automatic out_pkt(int len, int crc);
    int b[$];
    for (int i = 0; i < len; i++) begin
      b.push_back($urandom_range(0, 255));
      exp_q.push_back(e_out(b[i]));
    end
    if (crc != 0) exp_q.push_back(e_hsk(0));
    pulse_out();
    rx_pkt(len, crc, b);
    tick(2);
  endtask

  initial begin
    trn_setup = 0; trn_in = 0; trn_out = 0; trn_endpoint = 0;
    rx_tdata = 0; rx_tvalid = 0; rx_tlast = 0; rx_crc_ok = 0;
    host_ack = 0; ctl_xfer_accept = 1; ctl_xfer_done = 0;
    tick(3); rst = 1'b0; tick();
    chk("rst_hsk_valid", int'(hsk_valid), 0);
    chk("rst_tx_tvalid", int'(tx_tvalid), 0);
    chk("rst_ctl_xfer", int'(ctl_xfer), 0);
    chk("rst_length", int'(ctl_xfer_length), 0);
    chk("rst_in_ready", int'(ctl_xfer_data_in_ready), 0);
    chk("rst_tx_data1", int'(tx_data1), 0);

    in_xfer(18, 18, 1, 1, 0);
    in_xfer(9, 18, 0, 0, 0);
    in_xfer(255, 64, 0, 0, 0);
    in_xfer(16, 16, 0, 0, 0);
    in_xfer(40, 18, 0, 0, 1);
    for (int k = 0; k < 6; k++)
      in_xfer($urandom_range(1, 40), $urandom_range(1, 40),
              0, $urandom_range(0, 1), 0);

    setup(8'h00, 5, 16'h0005, 0);
    chk("set_addr_value", int'(ctl_xfer_value), 5);
    chk("set_addr_request", int'(ctl_xfer_request), 5);
    chk("set_addr_ctl_xfer", int'(ctl_xfer), 1);
    status_in(1);

    setup(8'h00, 9, 16'h0001, 10);
    out_pkt(8, 1);
    out_pkt(2, 0);
    out_pkt(2, 1);
    status_in(1);

    setup(8'h00, 5, 16'h0007, 0, 0);
    chk("bad_crc_setup", int'(ctl_xfer), 0);
    setup(8'h00, 5, 16'h0007, 0, 1, 7);
    chk("short_setup", int'(ctl_xfer), 0);
    pulse_in(); tick(2);
    chk("idle_drain", exp_q.size(), 0);

    ctl_xfer_accept = 1'b0;
    setup(8'h80, 8'h33, 0, 4);
    exp_q.push_back(e_hsk(REJ)); pulse_in();
    exp_q.push_back(e_hsk(REJ)); pulse_out();
    pulse_in(1); tick(3);
    chk("reject_drain", exp_q.size(), 0);
    ctl_xfer_accept = 1'b1;
    setup(8'h00, 5, 16'h0009, 0);
    chk("recover_value", int'(ctl_xfer_value), 9);
    status_in(0);

    for (int i = 0; i < 256; i++) hdat[i] = $urandom_range(0, 255);
    h_n = 18; h_idx = 0;
    setup(8'h80, 6, 16'h0100, 18);
    push_pkt(0, MPS, 1);
    tick(MPS + 4); pulse_in(); wait_txlast();
    rst = 1'b1; tick(2); rst = 1'b0; h_n = 0; tick(3);
    chk("reset_abort_xfer", int'(ctl_xfer), 0);
    chk("reset_abort_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/usb_ctl_xfer_ctrl.md
Name: usb_ctl_xfer_ctrl

Overview:
- Endpoint-0 control-transfer engine, device side.
- Sits between the USB token/packet layer and the control-request handlers, e.g. the standard-request responder.
- Captures the 8-byte SETUP payload, decodes it onto the ctl_xfer_* bus, and sequences the data stage: packetises IN data into MAX_PACKET_SIZE chunks with a retry buffer, and forwards OUT data.
- Runs the status stage and drops ctl_xfer only after the status stage completes, so deferred actions such as an address change take effect at the correct time.

Parameters:
- MAX_PACKET_SIZE, 64: EP0 max packet size in bytes. Legal values are 8, 16, 32, 64.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- trn_setup  in  1  pulse: SETUP token for this device
- trn_in  in  1  pulse: IN token
- trn_out  in  1  pulse: OUT token
- trn_endpoint  in  4  endpoint of the current token
- rx_tdata  in  8  received data-packet byte
- rx_tvalid  in  1  byte valid
- rx_tlast  in  1  last byte of packet
- rx_crc_ok  in  1  CRC16 good; sampled with rx_tlast
- host_ack  in  1  pulse: host ACK received for the last IN packet
- tx_tdata  out  8  IN packet byte
- tx_tvalid  out  1  byte valid
- tx_tlast  out  1  last byte, or the sole beat of a zero-length packet (ZLP)
- tx_zlp  out  1  qualifies tx_tlast as a ZLP; tx_tdata is ignored
- tx_tready  in  1  PHY accepts byte
- tx_data1  out  1  data toggle: 1 selects DATA1, 0 selects DATA0
- hsk_valid  out  1  handshake request pulse
- hsk_type  out  2  00 ACK, 01 NAK, 10 STALL
- ctl_xfer_endpoint  out  4  endpoint of the SETUP token
- ctl_xfer_type  out  8  bmRequestType
- ctl_xfer_request  out  8  bRequest
- ctl_xfer_value  out  16  wValue (little-endian assembled)
- ctl_xfer_index  out  16  wIndex
- ctl_xfer_length  out  16  wLength
- ctl_xfer  out  1  transfer active
- ctl_xfer_accept  in  1  a handler claims the request
- ctl_xfer_done  in  1  handler finished an OUT-direction transfer
- ctl_xfer_data_out  out  8  OUT data byte
- ctl_xfer_data_out_valid  out  1  OUT byte strobe
- ctl_xfer_data_in  in  8  IN data from handler
- ctl_xfer_data_in_valid  in  1  IN byte valid
- ctl_xfer_data_in_last  in  1  last IN byte from handler
- ctl_xfer_data_in_ready  out  1  engine consumes the byte

Behaviour:
- Reset values: all outputs 0; state IDLE; toggle 0; packet buffer count 0.
- Reset mid-transfer aborts the transfer with no handshake emitted.

States:
- IDLE, SETUP_RX, DECODE, IN_FILL, IN_SEND, IN_WAIT, OUT_RX, STATUS_IN, STATUS_OUT, STALL.

SETUP stage:
- trn_setup in any state forces SETUP_RX, aborts the current transfer and deasserts ctl_xfer.
- SETUP_RX latches the 8 bytes into the decode registers.
- rx_tlast with rx_crc_ok=1 and byte count == 8: emit ACK, set toggle to 1, go to DECODE.
- Otherwise: no handshake, return to IDLE.
- DECODE: ctl_xfer rises here and holds until the status stage completes.
- One cycle later, sample ctl_xfer_accept:
  - Accepted, bmRequestType[7]=1 and wLength>0: IN_FILL.
  - Accepted, bmRequestType[7]=0 and wLength>0: OUT_RX.
  - Accepted, wLength==0: STATUS_IN.
  - Not accepted: STALL.

IN data stage:
- IN_FILL: assert ctl_xfer_data_in_ready; store bytes into the MAX_PACKET_SIZE-byte buffer.
- Stop filling when any of these occurs: the buffer is full; ctl_xfer_data_in_last is accepted; total bytes sent == wLength (16-bit remaining counter, no wrap).
- Then go to IN_SEND, waiting for trn_in if it has not yet arrived.
- Any trn_in during IN_FILL is answered with NAK.
- IN_SEND streams the buffer with the current toggle.
  - An empty buffer is sent as a ZLP.
  - A ZLP is also required when the previous packet was exactly MAX_PACKET_SIZE, the handler signalled last, and total < wLength.
- IN_WAIT:
  - host_ack: flip toggle. Go to STATUS_OUT if the stage is finished, else clear the buffer and go to IN_FILL.
  - trn_in before host_ack: resend the same buffer with the same toggle.
  - trn_out: treated as early status; go to STATUS_OUT.

OUT data stage:
- OUT_RX: bytes are forwarded one per rx_tvalid on ctl_xfer_data_out/_valid.
- Good CRC: emit ACK and flip toggle.
- Bad CRC: no handshake.
- The stage ends when the byte count reaches wLength, then go to STATUS_IN.

Status stages:
- STATUS_IN: on trn_in, if the transfer is OUT-direction and ctl_xfer_done=0, emit NAK; otherwise send a DATA1 ZLP. host_ack then clears ctl_xfer and returns to IDLE.
- STATUS_OUT: on a DATA1 ZLP with good CRC, emit ACK, clear ctl_xfer, return to IDLE.

Other rules:
- Tokens whose trn_endpoint is not 0 are ignored.
- Within a cycle, a handshake is emitted at most once, as a 1-cycle hsk_valid pulse.

Optional Feature:
- USB_CTL_STALL_EN defined: STALL state answers every IN/OUT token with hsk_type=10 until the next trn_setup.
- Undefined: STALL state answers with NAK instead. Unsupported requests then time out at the host; trn_setup still recovers.

Test Plan:
1. GET_DESCRIPTOR(device), wLength=18, handler supplies 18 bytes, MPS=64 -> one 18-byte DATA1 packet; STATUS_OUT ZLP gets ACK; ctl_xfer falls after the ACK.
2. Same request, wLength=9 -> 9-byte packet; ctl_xfer_data_in_ready low after byte 9; no last needed.
3. MPS=8, 18-byte descriptor -> packets of 8, 8, 2 bytes with toggles 1, 0, 1. Repeated trn_in without host_ack -> identical 8 bytes, toggle unchanged.
4. SET_ADDRESS value=0x0005, wLength=0 -> trn_in gets a DATA1 ZLP; ctl_xfer stays high until host_ack, then drops.
5. Handler supplies exactly 64 bytes with last, wLength=255 -> a 64-byte packet followed by a ZLP.
6. Request with ctl_xfer_accept=0 -> with USB_CTL_STALL_EN, trn_in gets hsk_type=10; without it, NAK. A subsequent trn_setup is accepted normally.
